// File: rtl/omem_responder_if.sv
// Output-memory port bundle between the MAC array / host and the OMEM responder.
// Array side: EN_O, RW_O, ADDR_O, WDATA_O in; RDATA_O out (1-cycle read latency).
// Host side:  CLEAR, DRAIN_START, DRAIN_LAST, OUT_READY in;
//             OUT_VALID, OUT_DATA, OUT_ADDR, DRAIN_BUSY, DRAIN_DONE, WRITTEN out.
// The slave modport is the responder; the master modport is whoever drives it.
interface omem_responder_if #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 64
);
  logic          EN_O;
  logic          RW_O;
  logic [AW-1:0] ADDR_O;
  logic [DW-1:0] WDATA_O;
  logic [DW-1:0] RDATA_O;
  logic          CLEAR;
  logic          DRAIN_START;
  logic [AW-1:0] DRAIN_LAST;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] OUT_DATA;
  logic [AW-1:0] OUT_ADDR;
  logic          DRAIN_BUSY;
  logic          DRAIN_DONE;
  logic [DEPTH-1:0] WRITTEN;

  modport slave (
    input  EN_O, RW_O, ADDR_O, WDATA_O, CLEAR, DRAIN_START, DRAIN_LAST, OUT_READY,
    output RDATA_O, OUT_VALID, OUT_DATA, OUT_ADDR, DRAIN_BUSY, DRAIN_DONE, WRITTEN
  );

  modport master (
    output EN_O, RW_O, ADDR_O, WDATA_O, CLEAR, DRAIN_START, DRAIN_LAST, OUT_READY,
    input  RDATA_O, OUT_VALID, OUT_DATA, OUT_ADDR, DRAIN_BUSY, DRAIN_DONE, WRITTEN
  );
endinterface

// File: rtl/omem_responder.sv
// OMEM responder: DEPTH x DW register file serving the MAC array (write, or read
// with 1-cycle latency) plus a host drain engine streaming entries 0..DRAIN_LAST
// over a valid/ready channel. Tracks a written flag per entry.
// Ports: CLK, RSTN (async active-low), bus (omem_responder_if.slave).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting; CLEAR and DRAIN_START accepted only here
// S_FETCH | read mem[ptr] into the output register when array is idle
// S_HOLD  | OUT_VALID high, word held until OUT_READY
// S_DONE  | one-cycle DRAIN_DONE pulse, then back to S_IDLE
module omem_responder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 64
) (
  input logic              CLK,
  input logic              RSTN,
  omem_responder_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] written_q, written_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [AW-1:0]    out_addr_q, out_addr_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    last_q, last_d;

  logic clear_acc;
  logic array_wr;
  logic array_rd;

  assign clear_acc = bus.CLEAR && (state_q == S_IDLE);
  assign array_wr  = bus.EN_O && bus.RW_O;
  assign array_rd  = bus.EN_O && !bus.RW_O;

  always_comb begin
    mem_d       = mem_q;
    written_d   = written_q;
    rdata_d     = rdata_q;
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;

    // Clear first so a same-cycle array write survives with its flag set.
    if (clear_acc) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      written_d = '0;
    end
    if (array_wr) begin
      mem_d[bus.ADDR_O]     = bus.WDATA_O;
      written_d[bus.ADDR_O] = 1'b1;
    end
    // Reads see the pre-edge contents, so a same-cycle write is not visible.
    if (array_rd) rdata_d = mem_q[bus.ADDR_O];

    case (state_q)
      S_IDLE: begin
        if (bus.DRAIN_START) begin
          ptr_d   = '0;
          last_d  = bus.DRAIN_LAST;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // Single-port storage: the array owns any cycle with EN_O high.
        if (!bus.EN_O) begin
          out_data_d  = mem_q[ptr_q];
          out_addr_d  = ptr_q;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.OUT_READY) begin
          out_valid_d = 1'b0;
          if (ptr_q == last_q) begin
            state_d = S_DONE;
          end else begin
            ptr_d   = ptr_q + AW'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      written_q   <= '0;
      rdata_q     <= '0;
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      written_q   <= written_d;
      rdata_q     <= rdata_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
    end
  end

  assign bus.RDATA_O    = rdata_q;
  assign bus.WRITTEN    = written_q;
  assign bus.OUT_VALID  = out_valid_q;
  assign bus.OUT_DATA   = out_data_q;
  assign bus.OUT_ADDR   = out_addr_q;
  assign bus.DRAIN_BUSY = (state_q == S_FETCH) || (state_q == S_HOLD);
  assign bus.DRAIN_DONE = (state_q == S_DONE);

endmodule
